mem_responder: RTL

Word-organised, byte-addressable memory that serves load/store/fetch requests from the multicycle RISC-V core. It accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states. It performs byte/half/word lane selection and load extension from the RV32I funct3 encoding. It flags misaligned and out-of-range accesses instead of committing them.

---
 rtl/mem_responder_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 60 ++++++
 rtl/mem_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared constants for the memory responder: RV32I funct3 size codes,
//   responder FSM states and a size-legality helper.
package mem_responder_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic size_legal(input logic [2:0] size);
        case (size)
            SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: size_legal = 1'b1;
            default:                        size_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Combinational byte-lane steering for a 32-bit word memory.
//   Ports:
//     addr_lo    in  2   byte offset within the word
//     size       in  3   RV32I funct3 size code
//     wdata      in  32  right-aligned store data
//     rword      in  32  word read from the array
//     byte_en    out 4   lanes written by a store
//     wdata_lane out 32  store data replicated onto every lane
//     rdata_ext  out 32  selected lane, sign/zero extended
//     misalign   out 1   half not on 2-byte or word not on 4-byte boundary
module mem_lane_align
    import mem_responder_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword[{addr_lo, 3'b000} +: 8];
    assign half_sel = rword[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        byte_en    = '0;
        wdata_lane = '0;
        rdata_ext  = '0;
        misalign   = 1'b0;
        case (size)
            SZ_B, SZ_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = (size == SZ_B) ? {{24{byte_sel[7]}}, byte_sel}
                                            : {24'h0, byte_sel};
            end
            SZ_H, SZ_HU: begin
                misalign   = addr_lo[0];
                byte_en    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = (size == SZ_H) ? {{16{half_sel[15]}}, half_sel}
                                            : {16'h0, half_sel};
            end
            SZ_W: begin
                misalign   = (addr_lo != 2'b00);
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(4 * DEPTH_WORDS);
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [2:0]    lat_size;
  logic [31:0]   lat_wdata;

  // With zero wait states the access executes on the accepting edge, so the
  // live request fields stand in for the not-yet-latched ones.
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [2:0]    acc_size;
  logic [31:0]   acc_wdata;
  logic          acc_err;
  logic          exec;
  logic [31:0]   rword;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_lane;
  logic [31:0]   rdata_ext;
  logic          misalign;
  logic [31:0]   rsp_data_next;

  always_comb begin
    if (state == ST_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_size  = req_size;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_size  = lat_size;
      acc_wdata = lat_wdata;
    end
  end

  assign rword   = mem[acc_addr[AW-1:2]];
  assign acc_err = misalign || !size_legal(acc_size) || (acc_addr >= ADDR_LIMIT);
  assign exec    = ((state == ST_IDLE) && req_valid && (WAIT_CYCLES == 0))
                || ((state == ST_WAIT) && (cnt == '0));
  assign rsp_data_next = (acc_err || acc_we) ? '0 : rdata_ext;

  mem_lane_align u_align (
    .addr_lo    (acc_addr[1:0]),
    .size       (acc_size),
    .wdata      (acc_wdata),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign)
  );

  // Array is never reset; gating on rst keeps a store from landing while
  // reset is held.
  always_ff @(posedge clk) begin
    if (rst && exec && acc_we && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[acc_addr[AW-1:2]][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_size  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_size  <= req_size;
            lat_wdata <= req_wdata;
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= acc_err;
              rsp_rdata <= rsp_data_next;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= rsp_data_next;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
